// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - operation codes, unit select and instruction field constants for alu_ctrl_pipe
package alu_ctrl_pkg;

  localparam int OP_W_MIN = 5;

  typedef enum logic [OP_W_MIN-1:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_AND    = 5'd2,
    OP_OR     = 5'd3,
    OP_XOR    = 5'd4,
    OP_SLL    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_SLT    = 5'd8,
    OP_SLTU   = 5'd9,
    OP_BLTU   = 5'd10,
    OP_BEQ    = 5'd11,
    OP_BNE    = 5'd12,
    OP_BLT    = 5'd13,
    OP_BGE    = 5'd14,
    OP_PASSB  = 5'd15,
    OP_BGEU   = 5'd16,
    OP_MUL    = 5'd17,
    OP_MULH   = 5'd18,
    OP_MULHSU = 5'd19,
    OP_MULHU  = 5'd20,
    OP_DIV    = 5'd21,
    OP_DIVU   = 5'd22,
    OP_REM    = 5'd23,
    OP_REMU   = 5'd24
  } op_e;

  typedef enum logic [1:0] {
    UNIT_ALU = 2'd0,
    UNIT_MUL = 2'd1,
    UNIT_DIV = 2'd2
  } unit_e;

  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_ARITH = 2'b10;
  localparam logic [1:0] ALUOP_JUMP  = 2'b11;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  // Funct3 meaning shared by OP and OP-IMM when Funct7 is the base pattern
  function automatic op_e base_op(input logic [2:0] funct3);
    case (funct3)
      3'b000:  base_op = OP_ADD;
      3'b001:  base_op = OP_SLL;
      3'b010:  base_op = OP_SLT;
      3'b011:  base_op = OP_SLTU;
      3'b100:  base_op = OP_XOR;
      3'b101:  base_op = OP_SRL;
      3'b110:  base_op = OP_OR;
      default: base_op = OP_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational {ALUOp, OpImm, Funct7, Funct3} to {op, unit, illegal} decode
module alu_op_decode
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic       op_imm_i,
  input  logic [6:0] funct7_i,
  input  logic [2:0] funct3_i,
  output op_e        op_o,
  output unit_e      unit_o,
  output logic       illegal_o
);

  op_e   op_raw;
  unit_e unit_raw;
  logic  bad;

  always_comb begin
    op_raw   = OP_ADD;
    unit_raw = UNIT_ALU;
    bad      = 1'b0;
    case (alu_op_i)
      ALUOP_MEM: op_raw = OP_ADD;
      ALUOP_BR: begin
        case (funct3_i)
          3'b000:  op_raw = OP_BEQ;
          3'b001:  op_raw = OP_BNE;
          3'b100:  op_raw = OP_BLT;
          3'b101:  op_raw = OP_BGE;
          3'b110:  op_raw = OP_BLTU;
          3'b111:  op_raw = OP_BGEU;
          default: bad    = 1'b1;
        endcase
      end
      ALUOP_ARITH: begin
        if (op_imm_i) begin
          // Immediate forms only look at Funct7 for the shift encodings
          op_raw = base_op(funct3_i);
          if (funct3_i == 3'b001) begin
            bad = (funct7_i != F7_BASE);
          end else if (funct3_i == 3'b101) begin
            if (funct7_i == F7_ALT) begin
              op_raw = OP_SRA;
            end else begin
              bad = (funct7_i != F7_BASE);
            end
          end
        end else begin
          case (funct7_i)
            F7_BASE: op_raw = base_op(funct3_i);
            F7_ALT: begin
              if (funct3_i == 3'b000) begin
                op_raw = OP_SUB;
              end else if (funct3_i == 3'b101) begin
                op_raw = OP_SRA;
              end else begin
                bad = 1'b1;
              end
            end
            F7_MEXT: begin
              op_raw   = op_e'(OP_MUL + 5'(funct3_i));
              unit_raw = funct3_i[2] ? UNIT_DIV : UNIT_MUL;
            end
            default: bad = 1'b1;
          endcase
        end
      end
      default: op_raw = (funct3_i == 3'b000) ? OP_ADD : OP_PASSB;
    endcase
  end

  assign op_o      = bad ? OP_ADD : op_raw;
  assign unit_o    = bad ? UNIT_ALU : unit_raw;
  assign illegal_o = bad;

endmodule

// File: rtl/alu_ctrl_pipe.sv
// rtl/alu_ctrl_pipe.sv - registered ALU/MDU operation control with fixed-latency multiply/divide sequencing
module alu_ctrl_pipe
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W    = 5,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 33
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  input  logic [1:0]      ALUOp,
  input  logic            OpImm,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic            flush,
  output logic [OP_W-1:0] Operation,
  output logic            op_valid,
  output logic [1:0]      unit_sel,
  output logic            illegal,
  output logic            stall,
  output logic            mdu_start,
  output logic            mdu_done
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT) + 1;
  localparam logic [CW-1:0] MUL_M1 = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_M1 = CW'(DIV_LAT - 1);

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [OP_W-1:0] op_q, op_d;
  unit_e           unit_q, unit_d;
  logic            illegal_q, illegal_d;
  logic            valid_q, valid_d;
  logic            start_q, start_d;
  logic            done_q, done_d;

  op_e           dec_op;
  unit_e         dec_unit;
  logic          dec_illegal;
  logic          accept;
  logic [CW-1:0] lat_m1;

  alu_op_decode u_decode (
    .alu_op_i  (ALUOp),
    .op_imm_i  (OpImm),
    .funct7_i  (Funct7),
    .funct3_i  (Funct3),
    .op_o      (dec_op),
    .unit_o    (dec_unit),
    .illegal_o (dec_illegal)
  );

  // stall depends on state only, so accept never loops back through the hazard unit
  assign stall  = (state_q == ST_BUSY);
  assign accept = in_valid & ~stall & ~flush;
  assign lat_m1 = (dec_unit == UNIT_MUL) ? MUL_M1 : DIV_M1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    unit_d    = unit_q;
    illegal_d = illegal_q;
    valid_d   = 1'b0;
    start_d   = 1'b0;
    done_d    = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (state_q == ST_BUSY) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end else if (accept) begin
      op_d      = OP_W'(dec_op);
      unit_d    = dec_unit;
      illegal_d = dec_illegal;
      valid_d   = 1'b1;
      if (dec_unit != UNIT_ALU) begin
        start_d = 1'b1;
        cnt_d   = lat_m1;
        if (lat_m1 == '0) begin
          done_d = 1'b1;
        end else begin
          state_d = ST_BUSY;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      unit_q    <= UNIT_ALU;
      illegal_q <= 1'b0;
      valid_q   <= 1'b0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      unit_q    <= unit_d;
      illegal_q <= illegal_d;
      valid_q   <= valid_d;
      start_q   <= start_d;
      done_q    <= done_d;
    end
  end

  assign Operation = op_q;
  assign unit_sel  = unit_q;
  assign illegal   = illegal_q;
  assign op_valid  = valid_q;
  assign mdu_start = start_q;
  assign mdu_done  = done_q;

endmodule
